// File: rtl/div_share_arb.sv
// Round-robin arbiter that time-shares one multicycle divider between N_REQ requesters.
// Zero operands are answered directly; a watchdog aborts a divider that never reports done.
module div_share_arb #(
    parameter int N_REQ   = 4,
    parameter int N_BITS  = 32,
    parameter int TIMEOUT = 64
) (
    input  logic                      clk_i,
    input  logic                      rst_n_i,
    input  logic [N_REQ-1:0]          req_valid_i,
    output logic [N_REQ-1:0]          req_ready_o,
    input  logic [N_REQ*N_BITS-1:0]   req_n_i,
    input  logic [N_REQ*N_BITS-1:0]   req_d_i,
    output logic [N_REQ-1:0]          rsp_valid_o,
    input  logic [N_REQ-1:0]          rsp_ready_i,
    output logic [N_BITS-1:0]         rsp_q_o,
    output logic [N_BITS-1:0]         rsp_r_o,
    output logic                      rsp_dz_o,
    output logic                      rsp_err_o,
    output logic                      div_en_o,
    output logic [N_BITS-1:0]         div_n_o,
    output logic [N_BITS-1:0]         div_d_o,
    input  logic [N_BITS-1:0]         div_q_i,
    input  logic [N_BITS-1:0]         div_r_i,
    input  logic                      div_valid_i
);
    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t                          state, state_nxt;
    logic [IW-1:0]                   ptr, gnt, gidx, ptr_nxt;
    logic                            found;
    int                              idx;
    logic [N_REQ-1:0][N_BITS-1:0]    n_arr, d_arr;
    logic [N_BITS-1:0]               sel_n, sel_d;
    logic [CW-1:0]                   cnt;
    logic                            cnt_hit;
    logic                            zero_op;
    logic [N_BITS-1:0]               q_reg, r_reg, dn_reg, dd_reg;
    logic                            dz_reg, err_reg;

    assign n_arr   = req_n_i;
    assign d_arr   = req_d_i;
    assign sel_n   = n_arr[gnt];
    assign sel_d   = d_arr[gnt];
    assign zero_op = (sel_d == '0) || (sel_n == '0);
    assign cnt_hit = (cnt == CW'(TIMEOUT - 1));
    assign ptr_nxt = (gnt == IW'(N_REQ - 1)) ? '0 : gnt + 1'b1;

    // First valid requester at or after ptr, wrapping around.
    always_comb begin
        found = 1'b0;
        gnt   = '0;
        idx   = 0;
        for (int i = 0; i < N_REQ; i++) begin
            idx = int'(ptr) + i;
            if (idx >= N_REQ) idx = idx - N_REQ;
            if (!found && req_valid_i[idx]) begin
                found = 1'b1;
                gnt   = IW'(idx);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (found) state_nxt = zero_op ? RESP : BUSY;
            BUSY: if (div_valid_i || cnt_hit) state_nxt = RESP;
            RESP: if (rsp_ready_i[gidx]) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        req_ready_o = '0;
        rsp_valid_o = '0;
        div_en_o    = 1'b0;
        case (state)
            IDLE: if (found && rst_n_i) req_ready_o[gnt] = 1'b1;
            BUSY: div_en_o = 1'b1;
            RESP: rsp_valid_o[gidx] = 1'b1;
            default: ;
        endcase
    end

    // Divider operands are only loaded on a real divide, so they hold across shortcuts.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            ptr     <= '0;
            gidx    <= '0;
            cnt     <= '0;
            dn_reg  <= '0;
            dd_reg  <= '0;
            q_reg   <= '0;
            r_reg   <= '0;
            dz_reg  <= 1'b0;
            err_reg <= 1'b0;
        end else begin
            case (state)
                IDLE: if (found) begin
                    gidx <= gnt;
                    ptr  <= ptr_nxt;
                    if (zero_op) begin
                        q_reg   <= '0;
                        r_reg   <= '0;
                        dz_reg  <= (sel_d == '0);
                        err_reg <= 1'b0;
                    end else begin
                        dn_reg <= sel_n;
                        dd_reg <= sel_d;
                        cnt    <= '0;
                    end
                end
                BUSY: begin
                    if (div_valid_i) begin
                        q_reg   <= div_q_i;
                        r_reg   <= div_r_i;
                        dz_reg  <= 1'b0;
                        err_reg <= 1'b0;
                    end else if (cnt_hit) begin
                        q_reg   <= '0;
                        r_reg   <= '0;
                        dz_reg  <= 1'b0;
                        err_reg <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign rsp_q_o   = q_reg;
    assign rsp_r_o   = r_reg;
    assign rsp_dz_o  = dz_reg;
    assign rsp_err_o = err_reg;
    assign div_n_o   = dn_reg;
    assign div_d_o   = dd_reg;

endmodule
